// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO pointer/occupancy controller.
// Holds the occupancy-state encoding and the default pointer width.
package fifo_pkg;

  localparam int DEF_ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } state_t;

endpackage

// File: rtl/ptr_counter.sv
// Wrapping pointer counter: advances by one on the edge after incr, wraps modulo 2**WIDTH.
// Latency one cycle; no backpressure, the caller gates incr.
module ptr_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             incr,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;

  always_comb begin
    out_d = out_q;
    if (incr) out_d = out_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) out_q <= '0;
    else        out_q <= out_d;
  end

  assign out = out_q;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller: RAM pointers, occupancy FSM, count, flags, ovf/udf pulses; no storage here.
// wr_en is same-cycle combinational; all else registered; rejected requests pulse ovf/udf next cycle.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd,
  input  logic                  wr,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  wr_en,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  ovf,
  output logic                  udf
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(AF_LEVEL);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  af_q, af_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  wr_acc;
  logic                  rd_acc;

  // Gating with reset keeps wr_en low and blocks acceptance while reset is held.
  assign wr_acc = reset & wr & ((state_q != FULL) | rd);
  assign rd_acc = reset & rd & (state_q != EMPTY);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (wr_acc && !rd_acc) begin
      count_d = count_q + ONE_C;
      state_d = (count_q == DEPTH_C - ONE_C) ? FULL : PARTIAL;
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - ONE_C;
      state_d = (count_q == ONE_C) ? EMPTY : PARTIAL;
    end
    af_d  = (count_d >= AF_C);
    ovf_d = reset & wr & ~rd & (state_q == FULL);
    udf_d = reset & rd & (state_q == EMPTY);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      count_q <= '0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  ptr_counter #(.WIDTH(ADDR_WIDTH)) u_wptr (
    .clk   (clk),
    .reset (reset),
    .incr  (wr_acc),
    .out   (w_addr)
  );

  ptr_counter #(.WIDTH(ADDR_WIDTH)) u_rptr (
    .clk   (clk),
    .reset (reset),
    .incr  (rd_acc),
    .out   (r_addr)
  );

  assign wr_en       = wr_acc;
  assign empty       = (state_q == EMPTY);
  assign full        = (state_q == FULL);
  assign almost_full = af_q;
  assign count       = count_q;
  assign ovf         = ovf_q;
  assign udf         = udf_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl (ADDR_WIDTH=4, AF_LEVEL=14) against an occupancy/pointer reference model.
module tb_fifo_ctrl;

  localparam int DEPTH = 16;
  localparam int AF    = 14;

  logic       clk = 1'b0;
  logic       reset;
  logic       rd;
  logic       wr;
  logic [3:0] w_addr;
  logic [3:0] r_addr;
  logic       wr_en;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic [4:0] count;
  logic       ovf;
  logic       udf;

  fifo_ctrl #(.ADDR_WIDTH(4), .AF_LEVEL(AF)) dut (
    .clk         (clk),
    .reset       (reset),
    .rd          (rd),
    .wr          (wr),
    .w_addr      (w_addr),
    .r_addr      (r_addr),
    .wr_en       (wr_en),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .count       (count),
    .ovf         (ovf),
    .udf         (udf)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: occupancy as an integer, pointers as accepted-operation tallies mod DEPTH.
  int   m_cnt = 0;
  int   m_wp  = 0;
  int   m_rp  = 0;
  logic m_ovf = 1'b0;
  logic m_udf = 1'b0;
  logic exp_wr_en;
  logic exp_rd_acc;
  int   exp_waddr;
  logic obs_wr_en;
  logic [3:0] obs_waddr;

  task automatic model_reset();
    m_cnt = 0; m_wp = 0; m_rp = 0; m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  // Drive one cycle of requests; entered and left at posedge+1.
  task automatic step(input logic rd_i, input logic wr_i);
    rd = rd_i;
    wr = wr_i;
    exp_wr_en  = wr_i && (m_cnt < DEPTH || rd_i);
    exp_rd_acc = rd_i && (m_cnt > 0);
    exp_waddr  = m_wp;
    @(negedge clk);
    obs_wr_en = wr_en;
    obs_waddr = w_addr;
    @(posedge clk);
    #1;
    m_ovf = wr_i && !rd_i && (m_cnt == DEPTH);
    m_udf = rd_i && (m_cnt == 0);
    if (exp_wr_en)  begin m_cnt++; m_wp = (m_wp + 1) % DEPTH; end
    if (exp_rd_acc) begin m_cnt--; m_rp = (m_rp + 1) % DEPTH; end
    rd = 1'b0;
    wr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; rd = 1'b0; wr = 1'b1;
    #3;
    n_total++; if (count !== 5'd0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
    n_total++; if (w_addr !== 4'd0 || r_addr !== 4'd0) $display("FAIL reset_ptrs: got w=%0d r=%0d want 0/0", w_addr, r_addr); else n_pass++;
    n_total++; if ({empty, full, almost_full, ovf, udf} !== 5'b10000) $display("FAIL reset_flags: got %b want 10000", {empty, full, almost_full, ovf, udf}); else n_pass++;
    n_total++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", wr_en); else n_pass++;
    @(posedge clk); @(posedge clk); #1;
    n_total++; if (count !== 5'd0 || w_addr !== 4'd0) $display("FAIL reset_hold: got count=%0d w=%0d want 0/0", count, w_addr); else n_pass++;
    @(negedge clk); reset = 1'b1; wr = 1'b0;
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1);
      n_total++; if (obs_wr_en !== 1'b1 || obs_waddr !== 4'(i)) $display("FAIL fill_write: got wr_en=%b addr=%0d want 1/%0d", obs_wr_en, obs_waddr, i); else n_pass++;
      n_total++; if (count !== 5'(i + 1)) $display("FAIL fill_count: got %0d want %0d", count, i + 1); else n_pass++;
      n_total++; if (almost_full !== (i + 1 >= AF)) $display("FAIL fill_af: got %b want %b at count %0d", almost_full, (i + 1 >= AF), i + 1); else n_pass++;
      n_total++; if (full !== (i == DEPTH - 1) || empty !== 1'b0) $display("FAIL fill_flags: got full=%b empty=%b at count %0d", full, empty, i + 1); else n_pass++;
    end
    n_total++; if (w_addr !== 4'd0) $display("FAIL fill_wrap: got w_addr=%0d want 0", w_addr); else n_pass++;
  endtask

  task automatic test_overflow();
    step(1'b0, 1'b1);
    n_total++; if (obs_wr_en !== 1'b0) $display("FAIL ovf_wr_en: got %b want 0", obs_wr_en); else n_pass++;
    n_total++; if (ovf !== 1'b1 || udf !== 1'b0) $display("FAIL ovf_pulse: got ovf=%b udf=%b want 1/0", ovf, udf); else n_pass++;
    n_total++; if (count !== 5'd16 || w_addr !== 4'd0 || full !== 1'b1) $display("FAIL ovf_hold: got count=%0d w=%0d full=%b want 16/0/1", count, w_addr, full); else n_pass++;
    step(1'b0, 1'b0);
    n_total++; if (ovf !== 1'b0) $display("FAIL ovf_one_cycle: got %b want 0", ovf); else n_pass++;
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0);
      n_total++; if (r_addr !== 4'((i + 1) % DEPTH) || count !== 5'(DEPTH - 1 - i)) $display("FAIL drain: got r=%0d count=%0d want %0d/%0d", r_addr, count, (i + 1) % DEPTH, DEPTH - 1 - i); else n_pass++;
      n_total++; if (empty !== (i == DEPTH - 1) || full !== 1'b0) $display("FAIL drain_flags: got empty=%b full=%b after read %0d", empty, full, i + 1); else n_pass++;
    end
    step(1'b1, 1'b0);
    n_total++; if (udf !== 1'b1 || r_addr !== 4'd0 || count !== 5'd0) $display("FAIL udf_pulse: got udf=%b r=%0d count=%0d want 1/0/0", udf, r_addr, count); else n_pass++;
    step(1'b0, 1'b0);
    n_total++; if (udf !== 1'b0) $display("FAIL udf_one_cycle: got %b want 0", udf); else n_pass++;
  endtask

  task automatic test_simultaneous();
    step(1'b1, 1'b1);
    n_total++; if (obs_wr_en !== 1'b1) $display("FAIL simul_empty_wr_en: got %b want 1", obs_wr_en); else n_pass++;
    n_total++; if (udf !== 1'b1 || count !== 5'd1 || empty !== 1'b0 || full !== 1'b0) $display("FAIL simul_empty: got udf=%b count=%0d empty=%b full=%b want 1/1/0/0", udf, count, empty, full); else n_pass++;
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b1);
    n_total++; if (full !== 1'b1 || count !== 5'd16) $display("FAIL simul_refill: got full=%b count=%0d want 1/16", full, count); else n_pass++;
    step(1'b1, 1'b1);
    n_total++; if (obs_wr_en !== 1'b1) $display("FAIL simul_full_wr_en: got %b want 1", obs_wr_en); else n_pass++;
    n_total++; if (w_addr !== 4'(m_wp) || r_addr !== 4'(m_rp)) $display("FAIL simul_full_ptrs: got w=%0d r=%0d want %0d/%0d", w_addr, r_addr, m_wp, m_rp); else n_pass++;
    n_total++; if (full !== 1'b1 || count !== 5'd16 || ovf !== 1'b0) $display("FAIL simul_full_state: got full=%b count=%0d ovf=%b want 1/16/0", full, count, ovf); else n_pass++;
  endtask

  task automatic test_async_reset();
    time t0;
    reset = 1'b0; #2; reset = 1'b1;
    @(posedge clk); #1;
    model_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    n_total++; if (count !== 5'd5) $display("FAIL arst_load: got count=%0d want 5", count); else n_pass++;
    #2;
    t0 = $time;
    reset = 1'b0;
    wr = 1'b1;
    #1;
    n_total++; if (count !== 5'd0 || w_addr !== 4'd0 || r_addr !== 4'd0) $display("FAIL arst_async: got count=%0d w=%0d r=%0d want 0/0/0", count, w_addr, r_addr); else n_pass++;
    n_total++; if ({empty, full, almost_full, ovf, udf, wr_en} !== 6'b100000) $display("FAIL arst_flags: got %b want 100000", {empty, full, almost_full, ovf, udf, wr_en}); else n_pass++;
    n_total++; if (($time - t0) >= 4) $display("FAIL arst_timing: got %0t elapsed want under one half-cycle", $time - t0); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (count !== 5'd0 || w_addr !== 4'd0) $display("FAIL arst_no_accept: got count=%0d w=%0d want 0/0", count, w_addr); else n_pass++;
    @(negedge clk); reset = 1'b1; wr = 1'b0;
    @(posedge clk); #1;
    model_reset();
    step(1'b0, 1'b1);
    n_total++; if (obs_wr_en !== 1'b1 || obs_waddr !== 4'd0) $display("FAIL arst_first_write: got wr_en=%b addr=%0d want 1/0", obs_wr_en, obs_waddr); else n_pass++;
  endtask

  task automatic test_random();
    int wr_pct, rd_pct;
    for (int i = 0; i < 600; i++) begin
      wr_pct = (i < 200) ? 80 : (i < 400) ? 25 : 55;
      rd_pct = (i < 200) ? 25 : (i < 400) ? 80 : 50;
      step(($urandom_range(0, 99) < rd_pct), ($urandom_range(0, 99) < wr_pct));
      n_total++; if (obs_wr_en !== exp_wr_en || (exp_wr_en && obs_waddr !== 4'(exp_waddr))) $display("FAIL rand_wr_en[%0d]: got %b@%0d want %b@%0d", i, obs_wr_en, obs_waddr, exp_wr_en, exp_waddr); else n_pass++;
      n_total++; if (count !== 5'(m_cnt)) $display("FAIL rand_count[%0d]: got %0d want %0d", i, count, m_cnt); else n_pass++;
      n_total++; if (w_addr !== 4'(m_wp) || r_addr !== 4'(m_rp)) $display("FAIL rand_ptrs[%0d]: got w=%0d r=%0d want %0d/%0d", i, w_addr, r_addr, m_wp, m_rp); else n_pass++;
      n_total++; if (empty !== (m_cnt == 0) || full !== (m_cnt == DEPTH) || almost_full !== (m_cnt >= AF)) $display("FAIL rand_flags[%0d]: got e=%b f=%b af=%b at count %0d", i, empty, full, almost_full, m_cnt); else n_pass++;
      n_total++; if (ovf !== m_ovf || udf !== m_udf) $display("FAIL rand_pulses[%0d]: got ovf=%b udf=%b want %b/%b", i, ovf, udf, m_ovf, m_udf); else n_pass++;
    end
  endtask

  initial begin
    rd = 1'b0;
    wr = 1'b0;
    reset = 1'b0;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish before 500000");
    $fatal(1);
  end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, sets pointer width; DEPTH = 2**ADDR_WIDTH entries.
REQ-002 Parameter AF_LEVEL, default DEPTH-2, is the occupancy at or above which almost_full asserts.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 rd  input  1  read request for the current cycle.
REQ-006 wr  input  1  write request for the current cycle.
REQ-007 w_addr  output  ADDR_WIDTH  RAM write address (write pointer).
REQ-008 r_addr  output  ADDR_WIDTH  RAM read address (read pointer).
REQ-009 wr_en  output  1  combinational RAM write strobe for the accepted write.
REQ-010 empty  output  1  registered; no stored entries.
REQ-011 full  output  1  registered; DEPTH stored entries.
REQ-012 almost_full  output  1  registered; count >= AF_LEVEL.
REQ-013 count  output  ADDR_WIDTH+1  registered occupancy, 0..DEPTH.
REQ-014 ovf  output  1  one-cycle pulse; write rejected.
REQ-015 udf  output  1  one-cycle pulse; read rejected.

Function
REQ-016 Occupancy FSM states EMPTY, PARTIAL, FULL; empty = (state==EMPTY), full = (state==FULL).
REQ-017 Accepted write: wr & (state!=FULL | rd); accepted read: rd & (state!=EMPTY).
REQ-018 wr_en SHALL equal the accepted-write term in the same cycle; w_addr addresses that write.
REQ-019 Accepted write: w_addr increments by 1 on the next edge; accepted read: r_addr increments by 1 on the next edge.
REQ-020 Pointers wrap modulo DEPTH (DEPTH-1 -> 0) with no other side effect.
REQ-021 count: +1 on write-only, -1 on read-only, unchanged on both or neither.
REQ-022 EMPTY -> PARTIAL on accepted write; with DEPTH==1, EMPTY -> FULL.
REQ-023 PARTIAL -> FULL when write-only and count==DEPTH-1; PARTIAL -> EMPTY when read-only and count==1; otherwise stays.
REQ-024 FULL -> PARTIAL on read-only; FULL with rd&wr stays FULL, both pointers advance.
REQ-025 EMPTY with rd&wr: write only accepted, read rejected (udf=1), next state PARTIAL, count=1.
REQ-026 ovf=1 on the cycle after wr asserted while FULL with rd=0; state, pointers and count unchanged.
REQ-027 udf=1 on the cycle after rd asserted while EMPTY; state, pointers and count unchanged.
REQ-028 almost_full updates on the same edge as count; never asserted while count < AF_LEVEL.
REQ-029 Invariant: count == (w_addr - r_addr) mod DEPTH, except count==DEPTH when FULL.

Reset
REQ-030 reset low SHALL immediately force state=EMPTY, w_addr=0, r_addr=0, count=0, empty=1, full=0, almost_full=0, ovf=0, udf=0, independent of clk.
REQ-031 Reset asserted mid-operation SHALL discard all occupancy; the first accepted write after release goes to address 0.
REQ-032 No request is accepted on any edge where reset is low; wr_en=0 while reset is low.

Structure
REQ-033 Shared package fifo_pkg holds the occupancy-state enum typedef (EMPTY, PARTIAL, FULL) and the default ADDR_WIDTH constant.
REQ-034 Sub-module ptr_counter (parameter WIDTH; ports clk, reset, incr, out; asynchronous active-low reset to 0; wraps) SHALL be instantiated twice, once per pointer.
REQ-035 FSM, count, flag and pulse logic reside in fifo_ctrl; no memory array in this block.

Verification (ADDR_WIDTH=4, AF_LEVEL=14)
REQ-036 Reset, then 16 writes with rd=0 -> w_addr 0..15 then 0, count=16, full=1 after the 16th edge, almost_full=1 from count=14.
REQ-037 From full, 17th write with rd=0 -> ovf pulses one cycle, count stays 16, w_addr stays 0, wr_en=0.
REQ-038 From full, 16 reads -> r_addr wraps to 0, empty=1, count=0; extra read -> udf pulse, r_addr unchanged.
REQ-039 From empty, rd=wr=1 one cycle -> wr_en=1, udf=1, count=1, state PARTIAL; from full, rd=wr=1 -> both pointers +1, full stays 1.
REQ-040 Load 5 entries, drop reset asynchronously between edges -> all outputs at reset values before the next posedge; next write uses w_addr=0.
